// File: rtl/merge_pkg.sv
// Shared definitions for the ping-pong merge-sort controller.
//   NUM_STAGES_DEF : default number of merge passes
//   N_DEF          : default element count (2**NUM_STAGES_DEF)
//   CNT_W_DEF      : default cycle-counter width
//   state_t        : one-hot controller FSM encoding
//   idx_w()        : stage-index width, never narrower than 1 bit
package merge_pkg;

  localparam int unsigned NUM_STAGES_DEF = 4;
  localparam int unsigned N_DEF          = 2 ** NUM_STAGES_DEF;
  localparam int unsigned CNT_W_DEF      = 16;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_RUN  = 4'b0010,
    ST_GAP  = 4'b0100,
    ST_FIN  = 4'b1000
  } state_t;

  function automatic int unsigned idx_w(input int unsigned stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/merge_pingpong_ctrl.sv
// Ping-pong bank controller for an HLS merge-sort pipeline. Runs the merge
// stages one after another, flipping the source bank after each pass, and
// presents an ap_ctrl_hs handshake to the caller.
// Ports:
//   ap_clk, ap_rst                     : clock, synchronous active-high reset
//   ap_start/ap_done/ap_continue/
//   ap_idle/ap_ready                   : top-level block handshake
//   stg_start/stg_done/stg_continue    : handshake to the selected stage
//   stg_idx                            : index of the active stage
//   src_bank                           : bank read by the active stage
//   run_width                          : sorted-run width, 1 << stg_idx
//   cyc_cnt                            : saturating RUN/GAP cycle count
module merge_pingpong_ctrl
  import merge_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             ap_start,
  output logic                             ap_done,
  input  logic                             ap_continue,
  output logic                             ap_idle,
  output logic                             ap_ready,
  output logic                             stg_start,
  input  logic                             stg_done,
  output logic                             stg_continue,
  output logic [idx_w(NUM_STAGES)-1:0]     stg_idx,
  output logic                             src_bank,
  output logic [NUM_STAGES:0]              run_width,
  output logic [CNT_W-1:0]                 cyc_cnt
);

  localparam int unsigned          IDX_W     = idx_w(NUM_STAGES);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES:0]  WIDTH_ONE = (NUM_STAGES + 1)'(1);

  state_t             r_state, w_state_nxt;
  logic               r_done_reg, w_done_reg_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_bank, w_bank_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state    <= ST_IDLE;
      r_done_reg <= 1'b0;
      r_idx      <= '0;
      r_bank     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_done_reg <= w_done_reg_nxt;
      r_idx      <= w_idx_nxt;
      r_bank     <= w_bank_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_bank_nxt   = r_bank;
    w_cnt_nxt    = r_cnt;
    ap_idle      = 1'b0;
    ap_ready     = 1'b0;
    stg_start    = 1'b0;
    stg_continue = 1'b0;

    w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Continue always wins; done is only latched when the consumer has not
    // acknowledged the FIN cycle itself.
    if (ap_continue)
      w_done_reg_nxt = 1'b0;
    else if (r_state == ST_FIN)
      w_done_reg_nxt = 1'b1;
    else
      w_done_reg_nxt = r_done_reg;

    case (r_state)
      ST_IDLE: begin
        ap_idle = ~ap_start;
        if (ap_start && !r_done_reg) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
          w_bank_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        stg_start = 1'b1;
        // Acknowledge in the same cycle so the stage never holds its done.
        stg_continue = stg_done;
        w_cnt_nxt    = w_cnt_inc;
        if (stg_done) begin
          w_bank_nxt = ~r_bank;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        // One dead cycle lets the bank muxes settle before the next start.
        w_cnt_nxt   = w_cnt_inc;
        w_state_nxt = ST_RUN;
      end
      ST_FIN: begin
        ap_ready    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ap_done   = (r_state == ST_FIN) | r_done_reg;
    stg_idx   = r_idx;
    src_bank  = r_bank;
    cyc_cnt   = r_cnt;
    run_width = WIDTH_ONE << r_idx;
  end

endmodule

// File: tb/tb_merge_pingpong_ctrl.sv
module tb_merge_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_continue = 1'b1;
  logic        stg_done = 1'b0;
  logic        ap_done, ap_idle, ap_ready, stg_start, stg_continue, src_bank;
  logic [1:0]  stg_idx;
  logic [4:0]  run_width;
  logic [15:0] cyc_cnt;

  logic        s_start = 1'b0;
  logic        s_stg_done = 1'b0;
  logic        s_ap_done, s_ap_idle, s_ap_ready, s_stg_start, s_stg_continue, s_src_bank;
  logic [1:0]  s_stg_idx;
  logic [4:0]  s_run_width;
  logic [3:0]  s_cyc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  merge_pingpong_ctrl #(.NUM_STAGES(4), .CNT_W(16)) dut (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .stg_start(stg_start), .stg_done(stg_done), .stg_continue(stg_continue),
    .stg_idx(stg_idx), .src_bank(src_bank), .run_width(run_width), .cyc_cnt(cyc_cnt)
  );

  merge_pingpong_ctrl #(.NUM_STAGES(4), .CNT_W(4)) dut_sat (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(s_start), .ap_done(s_ap_done),
    .ap_continue(1'b1), .ap_idle(s_ap_idle), .ap_ready(s_ap_ready),
    .stg_start(s_stg_start), .stg_done(s_stg_done), .stg_continue(s_stg_continue),
    .stg_idx(s_stg_idx), .src_bank(s_src_bank), .run_width(s_run_width), .cyc_cnt(s_cyc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One stage pass on the main DUT: stg_done rises d cycles after stg_start.
  task automatic stage(input int d, input int idx, input logic bank, input bit spurious_gap);
    int n = 0;
    while (!stg_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_stg_start", 32'(stg_start), 32'd1);
    chk("stg_idx", 32'(stg_idx), 32'(idx));
    chk("src_bank", 32'(src_bank), 32'(bank));
    chk("run_width", 32'(run_width), 32'(1) << idx);
    chk("cont_before_done", 32'(stg_continue), 32'd0);
    repeat (d) @(negedge clk);
    stg_done = 1'b1;
    #1;
    chk("cont_pulse", 32'(stg_continue), 32'd1);
    @(negedge clk);
    stg_done = spurious_gap;
    #1;
    if (idx < 3) begin
      chk("gap_start_low", 32'(stg_start), 32'd0);
      chk("gap_idx", 32'(stg_idx), 32'(idx + 1));
      chk("gap_bank", 32'(src_bank), 32'(!bank));
      chk("gap_cont", 32'(stg_continue), 32'd0);
      if (spurious_gap) begin
        @(posedge clk);
        #1 stg_done = 1'b0;
        @(negedge clk);
      end
    end
    stg_done = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stg_start", 32'(stg_start), 32'd0);
    chk("rst_stg_cont", 32'(stg_continue), 32'd0);
    chk("rst_stg_idx", 32'(stg_idx), 32'd0);
    chk("rst_src_bank", 32'(src_bank), 32'd0);
    chk("rst_cyc_cnt", 32'(cyc_cnt), 32'd0);
    chk("rst_ap_done", 32'(ap_done), 32'd0);
    chk("rst_ap_ready", 32'(ap_ready), 32'd0);
    chk("rst_ap_idle", 32'(ap_idle), 32'd1);
    ap_start = 1'b1;
    #1 chk("idle_follows_start", 32'(ap_idle), 32'd0);
    ap_start = 1'b0;
    @(negedge clk);
    ap_rst = 1'b0;

    // Spurious done in IDLE
    @(negedge clk);
    stg_done = 1'b1;
    #1 chk("idle_spur_cont", 32'(stg_continue), 32'd0);
    @(negedge clk);
    #1;
    chk("idle_spur_start", 32'(stg_start), 32'd0);
    chk("idle_spur_idle", 32'(ap_idle), 32'd1);
    chk("idle_spur_idx", 32'(stg_idx), 32'd0);
    stg_done = 1'b0;

    // Nominal sort, 33-cycle stages, spurious done during first GAP
    @(negedge clk);
    ap_start = 1'b1;
    ap_continue = 1'b1;
    stage(33, 0, 1'b0, 1'b1);
    stage(33, 1, 1'b1, 1'b0);
    stage(33, 2, 1'b0, 1'b0);
    stage(33, 3, 1'b1, 1'b0);
    ap_start = 1'b0;
    #1;
    chk("nom_fin_done", 32'(ap_done), 32'd1);
    chk("nom_fin_ready", 32'(ap_ready), 32'd1);
    chk("nom_fin_idx", 32'(stg_idx), 32'd3);
    chk("nom_fin_bank", 32'(src_bank), 32'd0);
    chk("nom_fin_cnt", 32'(cyc_cnt), 32'd139);
    chk("nom_fin_start", 32'(stg_start), 32'd0);
    @(negedge clk);
    #1;
    chk("nom_idle_done", 32'(ap_done), 32'd0);
    chk("nom_idle_ready", 32'(ap_ready), 32'd0);
    chk("nom_idle_idle", 32'(ap_idle), 32'd1);
    chk("nom_idle_cnt", 32'(cyc_cnt), 32'd139);
    @(negedge clk);
    #1 chk("nom_hold_cnt", 32'(cyc_cnt), 32'd139);

    // Immediate done, start held so the next sort launches right after FIN
    ap_start = 1'b1;
    stage(0, 0, 1'b0, 1'b0);
    stage(0, 1, 1'b1, 1'b0);
    stage(0, 2, 1'b0, 1'b0);
    stage(0, 3, 1'b1, 1'b0);
    #1;
    chk("imm_fin_done", 32'(ap_done), 32'd1);
    chk("imm_fin_cnt", 32'(cyc_cnt), 32'd7);
    @(negedge clk);
    #1;
    chk("imm_idle_done", 32'(ap_done), 32'd0);
    chk("imm_idle_start", 32'(stg_start), 32'd0);
    chk("imm_idle_idle", 32'(ap_idle), 32'd0);
    @(negedge clk);
    #1;
    chk("restart_start", 32'(stg_start), 32'd1);
    chk("restart_cnt", 32'(cyc_cnt), 32'd0);

    // Reset in the middle of stage 2
    stage(3, 0, 1'b0, 1'b0);
    stage(3, 1, 1'b1, 1'b0);
    n = 0;
    while (!stg_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_run_idx", 32'(stg_idx), 32'd2);
    ap_rst = 1'b1;
    ap_start = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_start", 32'(stg_start), 32'd0);
    chk("mid_rst_idx", 32'(stg_idx), 32'd0);
    chk("mid_rst_bank", 32'(src_bank), 32'd0);
    chk("mid_rst_cnt", 32'(cyc_cnt), 32'd0);
    chk("mid_rst_idle", 32'(ap_idle), 32'd1);
    ap_rst = 1'b0;

    // Done hold with ap_continue low
    @(negedge clk);
    ap_start = 1'b1;
    ap_continue = 1'b0;
    stage(0, 0, 1'b0, 1'b0);
    stage(0, 1, 1'b1, 1'b0);
    stage(0, 2, 1'b0, 1'b0);
    stage(0, 3, 1'b1, 1'b0);
    #1 chk("hold_fin_done", 32'(ap_done), 32'd1);
    @(negedge clk);
    #1;
    chk("hold_done_1", 32'(ap_done), 32'd1);
    chk("hold_ready_0", 32'(ap_ready), 32'd0);
    chk("hold_ignore_1", 32'(stg_start), 32'd0);
    @(negedge clk);
    #1;
    chk("hold_done_2", 32'(ap_done), 32'd1);
    chk("hold_ignore_2", 32'(stg_start), 32'd0);
    ap_continue = 1'b1;
    @(negedge clk);
    #1;
    chk("hold_cleared", 32'(ap_done), 32'd0);
    chk("hold_still_idle", 32'(stg_start), 32'd0);
    @(negedge clk);
    #1;
    chk("hold_new_start", 32'(stg_start), 32'd1);
    chk("hold_new_cnt", 32'(cyc_cnt), 32'd0);
    ap_rst = 1'b1;
    ap_start = 1'b0;
    @(negedge clk);
    ap_rst = 1'b0;

    // Saturation on the 4-bit counter instance, 10-cycle stages
    @(negedge clk);
    s_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!s_stg_start && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("sat_wait_start", 32'(s_stg_start), 32'd1);
      chk("sat_idx", 32'(s_stg_idx), 32'(i));
      if (i == 1) chk("sat_cnt_mid", 32'(s_cyc_cnt), 32'd11);
      repeat (9) @(negedge clk);
      s_stg_done = 1'b1;
      @(negedge clk);
      s_stg_done = 1'b0;
    end
    s_start = 1'b0;
    #1;
    chk("sat_fin_done", 32'(s_ap_done), 32'd1);
    chk("sat_fin_cnt", 32'(s_cyc_cnt), 32'd15);
    chk("sat_fin_bank", 32'(s_src_bank), 32'd0);
    @(negedge clk);
    #1;
    chk("sat_idle", 32'(s_ap_idle), 32'd1);
    chk("sat_hold_cnt", 32'(s_cyc_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_pingpong_ctrl.md
MERGE_PINGPONG_CTRL -- requirements
Module: merge_pingpong_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of merge passes (N = 2**NUM_STAGES = 16 elements).
REQ-002 SHALL have parameter CNT_W, default 16, width of the cycle counter.
REQ-003 ap_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 ap_rst  in  1  reset, synchronous, active-high.
REQ-005 ap_start  in  1  top-level start (ap_ctrl_hs).
REQ-006 ap_done  out  1  sort complete; result valid in bank src_bank.
REQ-007 ap_continue  in  1  consumer acknowledges done.
REQ-008 ap_idle  out  1  controller idle.
REQ-009 ap_ready  out  1  ready for the next start.
REQ-010 stg_start  out  1  start to the merge stage selected by stg_idx.
REQ-011 stg_done  in  1  done from the selected stage (combinational HLS pulse).
REQ-012 stg_continue  out  1  continue to the selected stage.
REQ-013 stg_idx  out  $clog2(NUM_STAGES)  active stage index.
REQ-014 src_bank  out  1  bank read by the active stage; the stage writes ~src_bank.
REQ-015 run_width  out  NUM_STAGES+1  sorted-run width of the active stage = 1 << stg_idx.
REQ-016 cyc_cnt  out  CNT_W  cycles spent in RUN/GAP during the current or last sort.

Function
REQ-017 FSM states SHALL be IDLE, RUN, GAP and FIN, one-hot encoded.
REQ-018 In IDLE, ap_idle SHALL be 1 when ap_start=0, and 0 otherwise.
REQ-019 IDLE SHALL move to RUN when ap_start=1 and done_reg=0, loading stg_idx=0, src_bank=0 and cyc_cnt=0.
REQ-020 In RUN, stg_start SHALL be 1 and stg_continue SHALL equal stg_done (same cycle), so the stage never latches done.
REQ-021 When RUN sees stg_done=1, the controller SHALL toggle src_bank.
REQ-022 When RUN sees stg_done=1 and stg_idx<NUM_STAGES-1, the controller SHALL increment stg_idx and go to GAP.
REQ-023 When RUN sees stg_done=1 and stg_idx=NUM_STAGES-1, the controller SHALL go to FIN with stg_idx held.
REQ-024 GAP SHALL last exactly 1 cycle with stg_start=0 so the bank muxes settle, then go to RUN.
REQ-025 In FIN, ap_done and ap_ready SHALL be 1 for 1 cycle, and the FSM SHALL then go to IDLE.
REQ-026 done_reg SHALL set in FIN when ap_continue=0 and clear on any cycle with ap_continue=1.
REQ-027 ap_done SHALL be (FIN | done_reg).
REQ-028 ap_continue=1 in the FIN cycle SHALL leave done_reg=0, so a start in the next IDLE cycle is accepted.
REQ-029 ap_start while done_reg=1 SHALL be ignored; the FSM stays in IDLE.
REQ-030 After completion, src_bank SHALL equal NUM_STAGES mod 2 and identify the result bank (0 for the default).
REQ-031 cyc_cnt SHALL increment in RUN and GAP, saturate at all-ones, and hold its value in FIN and IDLE until the next start.
REQ-032 stg_done outside RUN SHALL be ignored: no state change and stg_continue=0.
REQ-033 run_width SHALL be derived combinationally from stg_idx.

Reset
REQ-034 ap_rst=1 at any time, including mid-sort, SHALL force IDLE on the next edge.
REQ-035 On reset, stg_start=0, stg_continue=0, stg_idx=0, src_bank=0, cyc_cnt=0, done_reg=0, ap_done=0 and ap_ready=0; ap_idle then follows ap_start.
REQ-036 Reset SHALL NOT reset any merge stage; the stages own their own reset.

Structure
REQ-037 Package merge_pkg SHALL hold NUM_STAGES, N, CNT_W defaults and the FSM state encoding constants.
REQ-038 The block SHALL be a single module with no sub-module; the saturating counter is inline.

Verification
REQ-039 Nominal: ap_start=1, ap_continue=1, each stage asserts stg_done 33 cycles after stg_start rises -> stg_idx sequence 0,1,2,3; src_bank sequence 0,1,0,1 then 0 at done; ap_done for 1 cycle; cyc_cnt=4*34+3=139.
REQ-040 Done hold: ap_continue=0 at FIN -> ap_done held at 1; ap_start=1 ignored; ap_continue=1 -> ap_done=0 next cycle and a new start is accepted the cycle after.
REQ-041 Reset mid-op: ap_rst=1 during RUN with stg_idx=2 -> next cycle IDLE, stg_start=0, stg_idx=0, src_bank=0, cyc_cnt=0.
REQ-042 Immediate done: stg_done=1 in the first RUN cycle of every stage -> 4 RUN + 3 GAP cycles, cyc_cnt=7, stg_continue pulses coincide with stg_done.
REQ-043 Spurious done: stg_done=1 in IDLE and in GAP -> no state change, stg_continue stays 0, stg_idx unchanged.
REQ-044 Saturation: CNT_W=4 with stages of 10 cycles -> cyc_cnt stops at 15 and holds after done.
